// File: rtl/fmadd_normalizer.sv
// rtl/fmadd_normalizer.sv - FMADD post-addition normaliser with exponent clamp and sticky collection
module fmadd_normalizer #(
    parameter int std = 31,
    parameter int man = 22,
    parameter int exp = 7
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*man+3:0]     in_mantissa,
    input  logic                 in_carry,
    input  logic [exp+1:0]       in_exp,
    input  logic                 in_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*man+3:0]     out_mantissa,
    output logic [exp+1:0]       out_exp,
    output logic                 out_sign,
    output logic                 out_sticky,
    output logic                 out_zero,
    output logic                 out_subnormal,
    output logic                 out_overflow
);

    localparam int MW = 2*man + 4;          // sum mantissa width
    localparam int EW = exp + 2;            // internal exponent width
    localparam int H  = 2*man + 2;          // hidden-bit position after normalisation
    localparam logic [EW-1:0] OVF_LIMIT = EW'((1 << (exp + 1)) - 1);
    localparam logic [EW-1:0] EXP_ONE   = EW'(1);
    localparam logic [EW-1:0] EXP_TWO   = EW'(2);
    localparam logic [EW-1:0] EXP_FOUR  = EW'(4);

    // The word layout (sign + exponent + mantissa) must fill the std-wide word.
    if (std == man + exp + 2) begin : g_layout_consistent
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   mant_q, mant_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic            sign_q, sign_d;
    logic            sticky_q, sticky_d;
    logic            zero_q, zero_d;

    // Full sum including the carry-out; bit MW is the carry.
    logic [MW:0]     v;
    assign v = {in_carry, in_mantissa};

    // One left-normalisation step: prefer the 4-bit jump, fall back to 1 bit.
    logic            can4, can1;
    logic [MW-1:0]   step_mant;
    logic [EW-1:0]   step_exp;
    logic            step_final;

    // Pick the left-shift step for this cycle and decide whether it is the last one.
    always_comb begin
        can4      = (mant_q[H -: 4] == 4'd0) && (exp_q > EXP_FOUR);
        can1      = !mant_q[H] && (exp_q > EXP_ONE);
        step_mant = mant_q;
        step_exp  = exp_q;
        if (can4) begin
            step_mant = mant_q << 4;
            step_exp  = exp_q - EXP_FOUR;
        end else if (can1) begin
            step_mant = mant_q << 1;
            step_exp  = exp_q - EXP_ONE;
        end
        // No further step is possible once the hidden bit is set or the
        // exponent reached the subnormal clamp.
        step_final = step_mant[H] || (step_exp <= EXP_ONE);
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    sticky_d = 1'b0;
                    zero_d   = 1'b0;
                    if (v == '0) begin
                        zero_d  = 1'b1;
                        mant_d  = '0;
                        exp_d   = '0;
                        state_d = DONE;
                    end else if (v[MW]) begin
                        // Carry out: two positions above the hidden bit.
                        mant_d   = {1'b0, v[MW:2]};
                        exp_d    = in_exp + EXP_TWO;
                        sticky_d = v[1] | v[0];
                        state_d  = DONE;
                    end else if (v[MW-1]) begin
                        mant_d   = v[MW:1];
                        exp_d    = in_exp + EXP_ONE;
                        sticky_d = v[0];
                        state_d  = DONE;
                    end else if (v[H]) begin
                        mant_d  = in_mantissa;
                        exp_d   = in_exp;
                        state_d = DONE;
                    end else begin
                        mant_d  = in_mantissa;
                        exp_d   = in_exp;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mant_d = step_mant;
                exp_d  = step_exp;
                if (step_final) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers holding the operation being normalised.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            mant_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            mant_q   <= mant_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign out_mantissa  = mant_q;
    assign out_exp       = exp_q;
    assign out_sign      = sign_q;
    assign out_sticky    = sticky_q;
    assign out_zero      = zero_q;
    assign out_subnormal = (state_q == DONE) && !mant_q[H] && (mant_q != '0);
    assign out_overflow  = (state_q == DONE) && (exp_q >= OVF_LIMIT);

endmodule

// File: doc/fmadd_normalizer.md
Name: fmadd_normalizer

Overview:
- Sequential post-addition normaliser for the FMADD datapath.
- Sits directly downstream of the mantissa-addition stage and consumes its sum mantissa and carry, together with the aligned exponent and result sign.
- Shifts the sum so the hidden bit sits at bit 2*man+2, adjusts the biased exponent, and collects sticky bits, clamps at subnormal, flags zero and overflow.
- Feeds the rounding stage over a valid/ready handshake.

Parameters:
- std, 31, total width of the single-precision word (kept for stage consistency).
- man, 22, mantissa field MSB index; the sum is 2*man+4 bits.
- exp, 7, exponent field MSB index; the internal exponent is exp+2 bits.

Ports:
- clk  input  1  clock, rising edge.
- rst_l  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream sum is valid.
- in_ready  output  1  normaliser can accept.
- in_mantissa  input  2*man+4  sum mantissa from the addition stage.
- in_carry  input  1  addition carry-out (bit 2*man+4 of the sum).
- in_exp  input  exp+2  biased exponent before normalisation.
- in_sign  input  1  result sign.
- out_valid  output  1  normalised result valid.
- out_ready  input  1  downstream accepts.
- out_mantissa  output  2*man+4  normalised mantissa.
- out_exp  output  exp+2  adjusted biased exponent.
- out_sign  output  1  sign passthrough.
- out_sticky  output  1  OR of all bits shifted out on the right.
- out_zero  output  1  sum was exactly zero.
- out_subnormal  output  1  left shift stopped by exponent clamp with bit 2*man+2 still clear.
- out_overflow  output  1  out_exp >= 2^(exp+1)-1.

Behaviour:
- Reset (async, rst_l=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - All other outputs and internal registers 0.
  - Applies from any state, including mid-SHIFT; the operation in flight is discarded.
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Notation: V = {in_carry, in_mantissa} (2*man+5 bits); H = bit index 2*man+2 (46 at defaults).
- IDLE, accept on in_valid & in_ready, latching sign, then:
  - V==0: out_zero=1, exp=0, mantissa 0, go DONE.
  - V[2*man+4]=1: shift right 2, exp+2, sticky=V[1]|V[0], go DONE.
  - else V[2*man+3]=1: shift right 1, exp+1, sticky=V[0], go DONE.
  - else V[H]=1: no shift, go DONE.
  - else: go SHIFT, sticky=0.
  - The latched mantissa is the low 2*man+4 bits after any shift.
- SHIFT, one step per cycle:
  - bits [H:H-3] all 0 and exp>4: shift left 4, exp-4.
  - else bit H=0 and exp>1: shift left 1, exp-1.
  - Go DONE on the same edge when the post-step value has bit H=1 or post-step exp<=1 (exp<=4 where only the 1-step applies).
  - If neither step is possible on entry, go DONE without shifting.
  - out_subnormal=1 when DONE is reached with bit H=0 and mantissa non-zero.
- Latency (accept edge to first cycle with out_valid=1):
  - 1 cycle for zero, right shift or already normalised.
  - Otherwise 1+floor(n/4)+(n mod 4) cycles, where n is the required left shift limited by the exponent clamp.
- DONE:
  - All outputs held stable while out_ready=0.
  - On out_ready=1, go IDLE, out_valid drops next cycle and in_ready rises the same cycle.
  - No accept in the DONE-exit cycle; in_valid while in_ready=0 is ignored and has no side effects.
- out_overflow is computed from the final exp in DONE.
- Exponent arithmetic is unsigned, exp+2 bits; inputs never exceed 2^(exp+2)-3, so +2 never wraps.
- out_sign equals the latched in_sign.

Test Plan:
- Normalised input: mant=0x4000_0000_0001, carry=0, exp=127 -> out_valid after 1 cycle; mant unchanged, exp=127, sticky=0, all flags 0.
- Carry input: carry=1, mant=0x0000_0000_0003, exp=127 -> mant=0x4000_0000_0000, exp=129, sticky=1, latency 1. Repeat with exp=254 -> exp=256, out_overflow=1.
- Left shift by 5: mant=0x0200_0000_0000, exp=127 -> one 4-step then one 1-step, latency 3; mant=0x4000_0000_0000, exp=122, subnormal=0.
- Subnormal clamp: mant=0x0000_0000_0100, exp=3 -> two 1-steps, latency 3; mant=0x0000_0000_0400, exp=1, out_subnormal=1.
- Zero sum: mant=0, carry=0, exp=90, sign=1 -> out_zero=1, exp=0, mant=0, sign=1, latency 1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0, a concurrent in_valid is not captured.
  - Then raise out_ready: in_ready=1 on the following cycle.
  - Separately, drive rst_l=0 mid-SHIFT: out_valid=0 and in_ready=1 immediately, with no clock edge required.
